// File: rtl/w_controller.sv
// Write-side FIFO handshake controller: captures a producer word through
// write_en/ready, commits it with a one-cycle ld1 strobe and advances wr_ptr.
module w_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              full,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              ld1,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   wr_ptr
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HS    = 2'b01,
        WRITE = 2'b10,
        STALL = 2'b11
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        ready      = 1'b0;
        ld1        = 1'b0;
        case (state)
            IDLE: begin
                if (write_en && !full) begin
                    next_state = HS;
                end else begin
                    next_state = IDLE;
                end
            end
            HS: begin
                ready = 1'b1;
                if (write_en) begin
                    next_state = HS;
                end else if (full) begin
                    next_state = STALL;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                ld1        = 1'b1;
                next_state = IDLE;
            end
            STALL: begin
                if (!full) begin
                    next_state = WRITE;
                end else begin
                    next_state = STALL;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sampling on every HS edge leaves the last handshake-cycle value in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data <= '0;
        end else if (state == HS) begin
            wr_data <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (state == WRITE) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign wr_addr = wr_ptr[ADDR_W-1:0];

endmodule

// File: tb/tb_w_controller.sv
// Directed, table-driven bench for w_controller plus hand-written sequences
// for async reset mid-handshake and pointer wrap.
module tb_w_controller;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_en = 1'b0;
    logic              full = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              ready;
    logic              ld1;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   wr_ptr;

    int compared = 0;
    int mismatched = 0;

    w_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .full(full), .din(din),
        .ready(ready), .ld1(ld1), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ptr(wr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       full;
        logic [7:0] din;
        logic       e_ready;
        logic       e_ld1;
        logic [3:0] e_ptr;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic f, logic [7:0] d,
                                logic er, logic el, logic [3:0] ep, logic [7:0] ed);
        vec_t v;
        v.rst = r; v.we = w; v.full = f; v.din = d;
        v.e_ready = er; v.e_ld1 = el; v.e_ptr = ep; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " ready"},   32'(ready),   32'(v.e_ready));
        check({tag, " ld1"},     32'(ld1),     32'(v.e_ld1));
        check({tag, " wr_ptr"},  32'(wr_ptr),  32'(v.e_ptr));
        check({tag, " wr_addr"}, 32'(wr_addr), 32'(v.e_ptr[2:0]));
        check({tag, " wr_data"}, 32'(wr_data), 32'(v.e_data));
    endtask

    task automatic do_write(input logic [7:0] d, input int unsigned idx);
        logic [3:0] exp_ptr;
        @(negedge clk); write_en = 1'b1; din = d;
        @(posedge clk); #1;
        check($sformatf("wrap%0d hs ready", idx), 32'(ready), 32'd1);
        @(negedge clk); write_en = 1'b0;
        @(posedge clk); #1;
        check($sformatf("wrap%0d ld1", idx), 32'(ld1), 32'd1);
        check($sformatf("wrap%0d wr_addr", idx), 32'(wr_addr), 32'(idx % 8));
        check($sformatf("wrap%0d wr_data", idx), 32'(wr_data), 32'(d));
        @(posedge clk); #1;
        exp_ptr = 4'(idx + 1);
        check($sformatf("wrap%0d wr_ptr", idx), 32'(wr_ptr), 32'(exp_ptr));
        check($sformatf("wrap%0d ld1 off", idx), 32'(ld1), 32'd0);
    endtask

    initial begin
        //                 rst we fu din     rdy ld1 ptr data
        vecs.push_back(mk(1, 0, 0, 8'h00,  0, 0, 0, 8'h00)); // reset
        vecs.push_back(mk(0, 1, 0, 8'hA5,  1, 0, 0, 8'h00)); // single write
        vecs.push_back(mk(0, 1, 0, 8'hA5,  1, 0, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 0, 8'hA5,  0, 1, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 0, 8'hA5,  0, 0, 1, 8'hA5));
        vecs.push_back(mk(0, 1, 0, 8'h11,  1, 0, 1, 8'hA5)); // last-value capture
        vecs.push_back(mk(0, 1, 0, 8'h11,  1, 0, 1, 8'h11));
        vecs.push_back(mk(0, 0, 0, 8'h22,  0, 1, 1, 8'h22));
        vecs.push_back(mk(0, 1, 0, 8'h22,  0, 0, 2, 8'h22)); // Idle not skipped
        vecs.push_back(mk(0, 1, 0, 8'h33,  1, 0, 2, 8'h22));
        vecs.push_back(mk(0, 0, 0, 8'h33,  0, 1, 2, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h33,  0, 0, 3, 8'h33)); // glitch in Write
        vecs.push_back(mk(0, 0, 0, 8'h33,  0, 0, 3, 8'h33));
        for (int i = 0; i < 5; i++)                          // full blocking
            vecs.push_back(mk(0, 1, 1, 8'h55,  0, 0, 3, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h44,  1, 0, 3, 8'h33)); // stall
        vecs.push_back(mk(0, 1, 1, 8'h44,  1, 0, 3, 8'h44));
        vecs.push_back(mk(0, 0, 1, 8'h44,  0, 0, 3, 8'h44));
        vecs.push_back(mk(0, 1, 1, 8'h99,  0, 0, 3, 8'h44));
        vecs.push_back(mk(0, 0, 1, 8'h99,  0, 0, 3, 8'h44));
        vecs.push_back(mk(0, 0, 0, 8'h99,  0, 1, 3, 8'h44));
        vecs.push_back(mk(0, 0, 0, 8'h99,  0, 0, 4, 8'h44));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; write_en = vecs[i].we;
            full = vecs[i].full; din = vecs[i].din;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset mid-clock while in HS, with nonzero ptr/data beforehand.
        @(negedge clk); write_en = 1'b1; full = 1'b0; din = 8'h77;
        @(posedge clk); #1;
        check("pre-reset ready", 32'(ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst ready", 32'(ready), 32'd0);
        check("async rst ld1", 32'(ld1), 32'd0);
        check("async rst wr_ptr", 32'(wr_ptr), 32'd0);
        check("async rst wr_data", 32'(wr_data), 32'd0);
        @(negedge clk); rst = 1'b0; write_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post-rst idle%0d", i), 32'(ready), 32'd0);
        end
        @(negedge clk); write_en = 1'b1;
        @(posedge clk); #1;
        check("post-rst leave idle", 32'(ready), 32'd1);

        // Restart from reset for the wrap sequence.
        @(negedge clk); rst = 1'b1; write_en = 1'b0;
        @(posedge clk); #1;
        check("wrap reset ptr", 32'(wr_ptr), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int unsigned i = 0; i < 9; i++)
            do_write(8'(8'hC0 + i), i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/w_controller.md
Name: w_controller

Overview:
- Write-side handshake controller for the design's FIFO; the producer-facing counterpart of the read-side controller.
- Accepts a word from the producer through a write_en/ready handshake and holds it in an internal register.
- Commits the held word to FIFO storage with a single-cycle write strobe.
- Owns the FIFO write pointer, including its wrap bit used by full/empty comparison logic.

Parameters:
- DATA_W, 8, width of the data word.
- ADDR_W, 3, FIFO address width (depth = 2^ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_en  input  1  producer request; held high while din is valid.
- full  input  1  FIFO full flag from pointer-compare logic.
- din  input  DATA_W  producer data.
- ready  output  1  handshake acknowledge to producer.
- ld1  output  1  one-cycle memory write strobe.
- wr_addr  output  ADDR_W  memory write address; equals wr_ptr[ADDR_W-1:0].
- wr_data  output  DATA_W  held data word presented to memory.
- wr_ptr  output  ADDR_W+1  write pointer; MSB is the wrap bit.

Behaviour:
- Reset (async, rst=1):
  - State = Idle; ready=0; ld1=0; wr_ptr=0; wr_data=0.
  - Takes effect immediately, including mid-handshake. A word captured but not yet written is discarded.
- States: Idle, HS, Write, Stall. Outputs are Moore, decoded from the present state only. State and registers update on the rising edge of clk.
- Idle:
  - ready=0, ld1=0.
  - write_en=1 and full=0 -> HS.
  - Otherwise stay in Idle. write_en high while full=1 is ignored; no data is captured.
- HS:
  - ready=1, ld1=0.
  - wr_data <= din on every clock edge spent in HS, so the value present on the last HS cycle is the one written.
  - write_en=1 -> stay in HS.
  - write_en=0 -> Write if full=0, Stall if full=1.
- Write:
  - ld1=1 for exactly one cycle, with wr_addr and wr_data stable during that cycle.
  - At the end of the cycle, wr_ptr <= wr_ptr + 1 (modulo 2^(ADDR_W+1)).
  - Next state is always Idle; Idle is not skipped even if write_en=1.
- Stall:
  - ready=0, ld1=0; wr_data held.
  - full=0 -> Write; otherwise stay in Stall. write_en is ignored in this state.
- Pointer arithmetic:
  - Low ADDR_W bits wrap from 2^ADDR_W-1 to 0, toggling the MSB.
  - Example (ADDR_W=3): wr_ptr 4'b0111 -> 4'b1000; 4'b1111 -> 4'b0000.
  - wr_ptr changes only on the Write -> Idle edge.
- Throughput: minimum 3 cycles per word (Idle, HS, Write), with the handshake lasting at least one cycle.
- full rising during HS: has no effect until write_en falls, then routes the FSM to Stall. No word is lost and no write occurs while full=1.
- write_en glitch in Write or Stall: no effect.
- Unused state encoding: next state = Idle, all outputs 0.

Test Plan:
- Reset: assert rst mid-clock with state in HS -> ready=0, ld1=0, wr_ptr=0, wr_data=0 before the next edge; the FSM leaves Idle only after rst=0 and write_en=1.
- Single write: full=0; write_en=1 for 2 cycles with din=8'hA5, then 0 -> ready high 2 cycles; next cycle ld1=1, wr_addr=0, wr_data=8'hA5; wr_ptr goes 0 -> 1.
- Last-value capture: din=8'h11 then 8'h22 across 2 HS cycles -> write cycle shows wr_data=8'h22.
- Full blocking: full=1 in Idle with write_en=1 for 5 cycles -> ready stays 0, ld1 stays 0, wr_ptr unchanged.
- Stall: full rises during HS, write_en falls -> FSM in Stall, ld1=0; release full after 3 cycles -> ld1=1 on the next cycle, wr_ptr increments once.
- Wrap: 9 back-to-back writes from reset with ADDR_W=3 -> wr_addr sequence 0..7,0; wr_ptr after the 8th write = 4'b1000, after the 9th = 4'b1001.
